// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the serial parity receiver.
// Holds the FSM state encoding (3-bit, shared with the transmitter side)
// and the line-level frame constants.
package serial_parity_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial receiver bus: the serial line in, the byte-wide result out.
//   rx_in      serial line (idle high)
//   data_out   last received word
//   data_valid one-cycle frame-complete strobe
//   parity_err parity mismatch of last frame
//   frame_err  stop bit sampled low on last frame
//   busy       receiver not idle
// master: the receiver. slave: the line driver / byte consumer.
interface serial_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    input  rx_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    output rx_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_parity_rx_xor2_nand.sv
// Two-input XOR built from four 2-input NANDs. Used for the parity
// accumulator update; the transmitter uses the same cell.
//   a, b  inputs
//   y     a ^ b
module xor2_nand (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n1, n2, n3;

  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign y  = ~(n2 & n3);
endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity,
// stop(1). rx_in is synchronised, each bit is sampled mid-cell, parity is
// accumulated through the NAND XOR cell, and the word plus parity/framing
// flags are registered on the stop-bit sample edge.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  serial_parity_rx_if master (rx_in in, data/flags/busy out)
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_parity_rx_if.master   bus
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = $clog2(DATA_W + 1);

  logic              sync1, rx_s;
  rx_state_e         state;
  logic [CW-1:0]     clk_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_acc, par_nxt, perr_q;
  logic              bit_tick, half_tick;

  // par_acc ^ current sample: the accumulator update in DATA, and the
  // final check value in PARITY (there the sample is the parity bit).
  xor2_nand u_par_xor (.a(par_acc), .b(rx_s), .y(par_nxt));

  // The IDLE cycle that sees the falling edge counts as cycle 0 of the
  // start cell, so the start sample lands at mid-cell after HALF-1 more.
  assign half_tick = (clk_cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign bit_tick  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign bus.busy  = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1          <= LINE_IDLE;
      rx_s           <= LINE_IDLE;
      state          <= ST_IDLE;
      clk_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_acc        <= 1'b0;
      perr_q         <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      sync1          <= bus.rx_in;
      rx_s           <= sync1;
      bus.data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          if (rx_s == START_BIT) begin
            state   <= ST_START;
            par_acc <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (half_tick) begin
            clk_cnt <= '0;
            // Line back high at mid-start: a glitch, drop it silently.
            state   <= (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            // LSB arrives first: shift in from the top.
            shreg   <= (shreg >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
            par_acc <= par_nxt;
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(DATA_W - 1)) state <= ST_PARITY;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            perr_q  <= par_nxt ^ ODD_PARITY;
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            clk_cnt        <= '0;
            // A bad stop bit still delivers the frame, just flagged.
            bus.data_out   <= shreg;
            bus.parity_err <= perr_q;
            bus.frame_err  <= (rx_s != STOP_BIT);
            bus.data_valid <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: one even-parity and one odd-parity receiver
// share the line. Frames are described as (word, parity bit, stop bit);
// the expected word, flags and pulse cycle are computed from the frame
// rules and queued, and a negedge monitor compares every data_valid pulse.
module tb_serial_parity_rx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  // posedges from the negedge rx_in falls to the edge that raises
  // data_valid: 2 sync + 1 idle detect + CPB/2 + (DW+2)*CPB
  localparam int LAT = 2 + 1 + CPB/2 + (DW + 2) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic busy_seen = 1'b0;

  typedef struct {
    int          fall;
    logic [DW-1:0] data;
    logic        pe0;
    logic        pe1;
    logic        fe;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_t[$];
  exp_t e;

  serial_parity_rx_if #(.DATA_W(DW)) bus0 ();
  serial_parity_rx_if #(.DATA_W(DW)) bus1 ();
  assign bus0.rx_in = rx_line;
  assign bus1.rx_in = rx_line;

  serial_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0))
    u_dut_even (.clk(clk), .rst(rst), .bus(bus0));
  serial_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1))
    u_dut_odd (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.busy) busy_seen = 1'b1;
    if (bus0.data_valid) begin
      pulse_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data_out",   bus0.data_out, e.data);
        chk("parity_err", bus0.parity_err, e.pe0);
        chk("frame_err",  bus0.frame_err, e.fe);
        chk("latency",    cyc - e.fall, LAT);
        chk("odd_valid",  bus1.data_valid, 1);
        chk("odd_parity_err", bus1.parity_err, e.pe1);
        chk("odd_data_out",   bus1.data_out, e.data);
      end
    end else if (bus1.data_valid) begin
      chk("odd_spurious_pulse", 1, 0);
    end
  end

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called on a negedge; leaves the line high on return (on a negedge).
  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop);
    exp_t x;
    int ones;
    ones = pbit;
    for (int i = 0; i < DW; i++) ones += d[i];
    x.fall = cyc;
    x.data = d;
    x.pe0  = (ones % 2) != 0;  // even parity: total ones must be even
    x.pe1  = (ones % 2) == 0;  // odd parity: total ones must be odd
    x.fe   = !stop;
    exp_q.push_back(x);
    hold_bit(1'b0);
    for (int i = 0; i < DW; i++) hold_bit(d[i]);
    hold_bit(pbit);
    hold_bit(stop);
    rx_line = 1'b1;
  endtask

  function automatic logic even_pbit(input logic [DW-1:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < DW; i++) ones += d[i];
    return logic'(ones % 2);
  endfunction

  initial begin
    int n;
    logic [DW-1:0] d;
    logic flip, stop;
    repeat (3) @(negedge clk);
    chk("rst_data_out",   bus0.data_out, 0);
    chk("rst_data_valid", bus0.data_valid, 0);
    chk("rst_parity_err", bus0.parity_err, 0);
    chk("rst_frame_err",  bus0.frame_err, 0);
    chk("rst_busy",       bus0.busy, 0);
    rst = 1'b0;
    idle(8);

    // clean frame, bad parity, bad stop
    send_frame(8'hA5, 1'b0, 1'b1); idle(10);
    send_frame(8'h01, 1'b0, 1'b1); idle(10);
    send_frame(8'h3C, 1'b0, 1'b0); idle(16);

    // one-clock glitch: busy rises, nothing else changes
    busy_seen = 1'b0;
    rx_line = 1'b0;
    @(negedge clk);
    idle(20);
    chk("glitch_busy_seen",  busy_seen, 1);
    chk("glitch_busy_now",   bus0.busy, 0);
    chk("glitch_data_out",   bus0.data_out, 8'h3C);
    chk("glitch_frame_err",  bus0.frame_err, 1);
    chk("glitch_parity_err", bus0.parity_err, 0);

    // reset in the middle of the data bits
    hold_bit(1'b0); hold_bit(1'b1); hold_bit(1'b0); hold_bit(1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_data_out",   bus0.data_out, 0);
    chk("midrst_frame_err",  bus0.frame_err, 0);
    chk("midrst_parity_err", bus0.parity_err, 0);
    chk("midrst_busy",       bus0.busy, 0);
    chk("midrst_valid",      bus0.data_valid, 0);
    rx_line = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    send_frame(8'h5A, 1'b0, 1'b1); idle(10);

    // back-to-back frames, no idle between stop and next start
    n = pulse_t.size();
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    idle(60);
    chk("b2b_pulses", pulse_t.size() - n, 2);
    if (pulse_t.size() >= n + 2)
      chk("b2b_gap", pulse_t[n+1] - pulse_t[n], (DW + 3) * CPB);

    // randomized frames: random word, ~1/4 bad parity, ~1/4 bad stop,
    // random gaps (a bad stop needs at least one idle bit cell after it)
    for (int k = 0; k < 24; k++) begin
      d    = DW'($urandom);
      flip = ($urandom_range(3) == 0);
      stop = ($urandom_range(3) != 0);
      send_frame(d, even_pbit(d) ^ flip, stop);
      idle(stop ? $urandom_range(7) : CPB + $urandom_range(7));
    end

    idle(60);
    chk("pending_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end
endmodule
